decode_cycle: RTL and testbench

Decode stage of the five-stage RISC-V pipeline: the consumer of the fetch stage's `InstrD`/`PCD`/`PCPlus4D` outputs. It decodes the instruction, reads the register file (which is written by the write-back stage), and generates the immediate and control signals. Results are registered into the ID/EX pipeline register for the execute stage. It holds the processor's architectural register state.

---
 rtl/riscv_pkg.sv | 53 +++++
 rtl/register_file.sv | 40 ++++
 rtl/decode_cycle.sv | 176 +++++++++++++++++
 tb/tb_decode_cycle.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: opcodes, control encodings and the
// control bundle carried from decode into execute.
package riscv_pkg;

  localparam int unsigned REG_AW  = 5;
  localparam int unsigned CTRL_W  = 10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  // Control bundle registered into ID/EX
  typedef struct packed {
    logic        reg_write;
    result_src_t result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    alu_ctrl_t   alu_ctrl;
    logic        alu_src;
  } ctrl_t;

endpackage

// File: rtl/register_file.sv
// Architectural register file: two combinational read ports with
// write-through, one write port, x0 reads as zero, synchronous clear.
// Ports: clk, rst (sync, active high), we/wa/wd write port,
//        ra1/ra2 read indices, rdata1/rdata2 read data.
module register_file
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [XLEN-1:0]   wd,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [XLEN-1:0]   rdata1,
  output logic [XLEN-1:0]   rdata2
);

  logic [XLEN-1:0] regs [NREG];
  logic            wr_en;

  assign wr_en = we && (wa != '0);

  // Storage update; reset wins over a coincident write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wa] <= wd;
    end
  end

  // Write-through lets a decode see a same-cycle write-back
  assign rdata1 = (ra1 == '0) ? '0 : (wr_en && ra1 == wa) ? wd : regs[ra1];
  assign rdata2 = (ra2 == '0) ? '0 : (wr_en && ra2 == wa) ? wd : regs[ra2];

endmodule

// File: rtl/decode_cycle.sv
// Decode stage: main/ALU control decode, immediate extension, register
// file read, and the ID/EX pipeline register.
// Ports: clk, rst (sync, active high); InstrD/PCD/PCPlus4D from fetch;
//        RegWriteW/RdW/ResultW from write-back; FlushE bubbles ID/EX;
//        Rs1D/Rs2D combinational source indices for the hazard unit;
//        *E outputs are the registered ID/EX contents.
module decode_cycle
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   InstrD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   PCPlus4D,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RdW,
  input  logic [XLEN-1:0]   ResultW,
  input  logic              FlushE,
  output logic [REG_AW-1:0] Rs1D,
  output logic [REG_AW-1:0] Rs2D,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              JumpE,
  output logic              BranchE,
  output logic              ALUSrcE,
  output logic [1:0]        ResultSrcE,
  output logic [2:0]        ALUControlE,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [REG_AW-1:0] Rs1E,
  output logic [REG_AW-1:0] Rs2E,
  output logic [REG_AW-1:0] RdE
);

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [REG_AW-1:0] rd;
  ctrl_t             ctrl;
  imm_src_t          imm_src;
  alu_op_t           alu_op;
  logic [XLEN-1:0]   imm_ext;
  logic [XLEN-1:0]   rd1;
  logic [XLEN-1:0]   rd2;
  logic              sign;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign rd     = InstrD[11:7];
  assign Rs1D   = InstrD[19:15];
  assign Rs2D   = InstrD[24:20];
  assign sign   = InstrD[31];

  register_file #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (RegWriteW),
    .wa     (RdW),
    .wd     (ResultW),
    .ra1    (Rs1D),
    .ra2    (Rs2D),
    .rdata1 (rd1),
    .rdata2 (rd2)
  );

  // Main decode then ALU decode; unknown opcodes decode to all-zero controls
  always_comb begin
    ctrl    = '0;
    imm_src = IMM_I;
    alu_op  = ALUOP_ADD;
    case (opcode)
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_MEM;
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm_src        = IMM_S;
      end
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        alu_op         = ALUOP_FUNCT;
      end
      OP_IALU: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        alu_op         = ALUOP_FUNCT;
      end
      OP_BRANCH: begin
        ctrl.branch = 1'b1;
        imm_src     = IMM_B;
        alu_op      = ALUOP_SUB;
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.result_src = RES_PC4;
        imm_src         = IMM_J;
      end
      default: ;
    endcase

    ctrl.alu_ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: ctrl.alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  ctrl.alu_ctrl = (opcode[5] && InstrD[30]) ? ALU_SUB : ALU_ADD;
          3'b010:  ctrl.alu_ctrl = ALU_SLT;
          3'b110:  ctrl.alu_ctrl = ALU_OR;
          3'b111:  ctrl.alu_ctrl = ALU_AND;
          default: ctrl.alu_ctrl = ALU_ADD;
        endcase
      end
      default: ctrl.alu_ctrl = ALU_ADD;
    endcase
  end

  // Immediate extension; B and J targets are halfword aligned
  always_comb begin
    imm_ext = {{(XLEN-12){sign}}, InstrD[31:20]};
    case (imm_src)
      IMM_S: imm_ext = {{(XLEN-12){sign}}, InstrD[31:25], InstrD[11:7]};
      IMM_B: imm_ext = {{(XLEN-12){sign}}, InstrD[7], InstrD[30:25],
                        InstrD[11:8], 1'b0};
      IMM_J: imm_ext = {{(XLEN-20){sign}}, InstrD[19:12], InstrD[20],
                        InstrD[30:21], 1'b0};
      default: ;
    endcase
  end

  // ID/EX register: reset and flush both insert an all-zero bubble
  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ResultSrcE  <= '0;
      ALUControlE <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
    end else begin
      RegWriteE   <= ctrl.reg_write;
      MemWriteE   <= ctrl.mem_write;
      JumpE       <= ctrl.jump;
      BranchE     <= ctrl.branch;
      ALUSrcE     <= ctrl.alu_src;
      ResultSrcE  <= ctrl.result_src;
      ALUControlE <= ctrl.alu_ctrl;
      RD1E        <= rd1;
      RD2E        <= rd2;
      ImmExtE     <= imm_ext;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
      RdE         <= rd;
    end
  end

endmodule

// File: tb/tb_decode_cycle.sv
// Randomized self-checking bench for decode_cycle against a behavioural
// model of the decode rules and an array model of the register file.
module tb_decode_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW, FlushE;
  logic [4:0]  RdW;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mregs [32];

  always #5 clk = ~clk;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .FlushE(FlushE),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .RD1E(RD1E),
    .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Immediate by instruction format, built arithmetically from field values
  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    int v;
    case (i[6:0])
      7'b0100011: v = (($signed(i) >>> 25) * 32) + int'(i[11:7]);
      7'b1100011: v = (i[31] ? -4096 : 0) + int'(i[7]) * 2048
                      + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
      7'b1101111: v = (i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096
                      + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
      default:    v = $signed(i) >>> 20;
    endcase
    return 32'(v);
  endfunction

  // {RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUControl[2:0], ALUSrc}
  function automatic logic [9:0] ref_ctrl(input logic [31:0] i);
    logic rw, mw, j, b, as;
    logic [1:0] rs;
    logic [2:0] alu;
    bit funct;
    {rw, mw, j, b, as, rs, alu, funct} = '0;
    case (i[6:0])
      7'b0000011: begin rw = 1; as = 1; rs = 2'd1; end
      7'b0100011: begin mw = 1; as = 1; end
      7'b0110011: begin rw = 1; funct = 1; end
      7'b0010011: begin rw = 1; as = 1; funct = 1; end
      7'b1100011: begin b = 1; alu = 3'd1; end
      7'b1101111: begin rw = 1; j = 1; rs = 2'd2; end
      default: ;
    endcase
    if (funct) begin
      if (i[14:12] == 3'd2) alu = 3'd5;
      else if (i[14:12] == 3'd6) alu = 3'd3;
      else if (i[14:12] == 3'd7) alu = 3'd2;
      else if (i[14:12] == 3'd0 && i[5] && i[30]) alu = 3'd1;
    end
    return {rw, rs, mw, j, b, alu, as};
  endfunction

  // One decode cycle: drive, check Rs1D/Rs2D, model the edge, check E outputs
  task automatic step(input logic [31:0] instr, input logic r, input logic fl,
                      input logic rw, input logic [4:0] rd, input logic [31:0] res);
    logic [31:0] pc, e_rd1, e_rd2, e_imm, e_pc, e_pc4;
    logic [9:0]  e_ctrl;
    logic [14:0] e_idx;
    pc = $urandom & 32'hFFFF_FFFC;
    InstrD = instr; PCD = pc; PCPlus4D = pc + 32'd4; rst = r; FlushE = fl;
    RegWriteW = rw; RdW = rd; ResultW = res;
    #1;
    check("rs1d", 32'(Rs1D), 32'(instr[19:15]));
    check("rs2d", 32'(Rs2D), 32'(instr[24:20]));
    {e_rd1, e_rd2, e_imm, e_pc, e_pc4, e_ctrl, e_idx} = '0;
    if (r) begin
      for (int k = 0; k < 32; k++) mregs[k] = '0;
    end else begin
      if (rw && rd != 0) mregs[rd] = res;
      if (!fl) begin
        e_rd1  = (instr[19:15] == 0) ? 32'd0 : mregs[instr[19:15]];
        e_rd2  = (instr[24:20] == 0) ? 32'd0 : mregs[instr[24:20]];
        e_imm  = ref_imm(instr);
        e_pc   = pc;
        e_pc4  = pc + 32'd4;
        e_ctrl = ref_ctrl(instr);
        e_idx  = {instr[19:15], instr[24:20], instr[11:7]};
      end
    end
    @(posedge clk);
    #1;
    check("ctrl", 32'({RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE}),
          32'(e_ctrl));
    check("rd1e", RD1E, e_rd1);
    check("rd2e", RD2E, e_rd2);
    check("immext", ImmExtE, e_imm);
    check("pce", PCE, e_pc);
    check("pcplus4e", PCPlus4E, e_pc4);
    check("idx", 32'({Rs1E, Rs2E, RdE}), 32'(e_idx));
  endtask

  localparam logic [6:0] OPS [6] = '{7'b0000011, 7'b0100011, 7'b0110011,
                                     7'b0010011, 7'b1100011, 7'b1101111};

  initial begin
    logic [31:0] ins;
    int sel;
    for (int k = 0; k < 32; k++) mregs[k] = '0;

    // reset held two cycles
    step(32'h0050_0093, 1, 0, 0, 5'd0, 32'd0);
    step(32'h0050_0093, 1, 0, 0, 5'd0, 32'd0);
    check("reset_regwrite", 32'(RegWriteE), 32'd0);
    check("reset_imm", ImmExtE, 32'd0);

    // addi x1,x0,5
    step(32'h0050_0093, 0, 0, 0, 5'd0, 32'd0);
    check("addi_imm", ImmExtE, 32'd5);
    check("addi_alusrc", 32'(ALUSrcE), 32'd1);
    check("addi_rd", 32'(RdE), 32'd1);

    // write-through: add x3,x2,x2 with same-cycle write of x2
    step(32'h0021_01B3, 0, 0, 1, 5'd2, 32'hDEAD_BEEF);
    check("wt_rd1", RD1E, 32'hDEAD_BEEF);
    check("wt_rd2", RD2E, 32'hDEAD_BEEF);

    // x0 write is discarded
    step(32'h0000_0013, 0, 0, 1, 5'd0, 32'h1234);
    step(32'h0000_0033, 0, 0, 0, 5'd0, 32'd0);
    check("x0_rd1", RD1E, 32'd0);

    // beq x0,x0,-8
    step(32'hFE00_0CE3, 0, 0, 0, 5'd0, 32'd0);
    check("beq_imm", ImmExtE, 32'hFFFF_FFF8);
    check("beq_alu", 32'(ALUControlE), 32'd1);

    // flush with a simultaneous write of x5, then read x5
    step(32'h0000_A103, 0, 1, 1, 5'd5, 32'd7);
    check("flush_regwrite", 32'(RegWriteE), 32'd0);
    step(32'h0002_8333, 0, 0, 0, 5'd0, 32'd0);
    check("flush_x5", RD1E, 32'd7);

    // randomized stream
    for (int n = 0; n < 600; n++) begin
      ins = $urandom;
      sel = $urandom_range(0, 7);
      if (sel < 6) ins[6:0] = OPS[sel];
      step(ins, ($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
